crossbar_rr: RTL and testbench

// - PORTS x PORTS circuit-switched crossbar for a NoC router node. Each input

---
 rtl/crossbar_rr.sv | 110 +++++++++++
 tb/tb_crossbar_rr.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_rr.sv
// Circuit-switched PORTS x PORTS crossbar with one round-robin arbiter per output.
// A granted input keeps its output while it keeps requesting it (wormhole locking).
module crossbar_rr #(
   parameter int  PORTS = 4,
   parameter int  WIDTH = 8,
   localparam int DW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORTS-1:0][WIDTH-1:0]   data_i,
   input  logic [PORTS-1:0]              bp_i,
   input  logic [PORTS-1:0][DW-1:0]      dest,
   input  logic [PORTS-1:0]              dest_en,
   output logic [PORTS-1:0][WIDTH-1:0]   data_o,
   output logic [PORTS-1:0]              bp_o,
   output logic [PORTS-1:0]              ack
);

   logic [PORTS-1:0]            owner_v_q, owner_v_d;
   logic [PORTS-1:0][DW-1:0]    owner_q, owner_d;
   logic [PORTS-1:0][DW-1:0]    rr_ptr_q, rr_ptr_d;

   logic [PORTS-1:0][PORTS-1:0] req_to;   // [output][input]
   logic [PORTS-1:0]            gnt_v;
   logic [PORTS-1:0]            gnt_new;
   logic [PORTS-1:0][DW-1:0]    gnt_idx;

   // Equality against an in-range output index also discards dest >= PORTS.
   always_comb begin
      req_to = '0;
      for (int o = 0; o < PORTS; o++) begin
         for (int i = 0; i < PORTS; i++) begin
            req_to[o][i] = dest_en[i] && (32'(dest[i]) == 32'(o));
         end
      end
   end

   always_comb begin
      int idx;
      idx     = 0;
      gnt_v   = '0;
      gnt_new = '0;
      gnt_idx = '0;
      for (int o = 0; o < PORTS; o++) begin
         if (owner_v_q[o] && req_to[o][owner_q[o]]) begin
            gnt_v[o]   = 1'b1;
            gnt_idx[o] = owner_q[o];
         end else begin
            for (int k = 0; k < PORTS; k++) begin
               idx = int'(rr_ptr_q[o]) + k;
               if (idx >= PORTS) idx = idx - PORTS;
               if (!gnt_v[o] && req_to[o][idx[DW-1:0]]) begin
                  gnt_v[o]   = 1'b1;
                  gnt_new[o] = 1'b1;
                  gnt_idx[o] = idx[DW-1:0];
               end
            end
         end
      end
   end

   // The pointer only moves on a fresh grant, so a held lock never skews fairness.
   always_comb begin
      int nxt;
      nxt       = 0;
      owner_v_d = gnt_v;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      for (int o = 0; o < PORTS; o++) begin
         if (gnt_v[o]) owner_d[o] = gnt_idx[o];
         if (gnt_new[o]) begin
            nxt = int'(gnt_idx[o]) + 1;
            if (nxt >= PORTS) nxt = 0;
            rr_ptr_d[o] = nxt[DW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_v_q <= '0;
         owner_q   <= '0;
         rr_ptr_q  <= '0;
      end else begin
         owner_v_q <= owner_v_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   // Ack/backpressure is a level, not a pulse: bp_o[i] mirrors the granted
   // output's bp_i every cycle the connection is held.
   always_comb begin
      data_o = '0;
      ack    = '0;
      bp_o   = '0;
      if (!rst) begin
         for (int o = 0; o < PORTS; o++) begin
            if (gnt_v[o]) begin
               data_o[o]        = data_i[gnt_idx[o]];
               ack[gnt_idx[o]]  = 1'b1;
            end
         end
         for (int i = 0; i < PORTS; i++) begin
            bp_o[i] = ack[i] && bp_i[dest[i]];
         end
      end
   end

endmodule

// File: tb/tb_crossbar_rr.sv
// Self-checking bench for crossbar_rr: vector table for the main paths, hand-written
// sequences for locking and mid-connection reset, scoreboard queue for expectations.
module tb_crossbar_rr;

   localparam int P  = 4;
   localparam int W  = 8;
   localparam int DW = 2;
   localparam int EW = P*W + 2*P;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [P-1:0][W-1:0]  data_i;
   logic [P-1:0]         bp_i;
   logic [P-1:0][DW-1:0] dest;
   logic [P-1:0]         dest_en;
   logic [P-1:0][W-1:0]  data_o;
   logic [P-1:0]         bp_o;
   logic [P-1:0]         ack;

   logic [EW-1:0] exp_q[$];
   string         name_q[$];
   int            checks = 0;
   int            errors = 0;

   typedef struct {
      string                name;
      logic [P-1:0][W-1:0]  di;
      logic [P-1:0]         bpi;
      logic [P-1:0][DW-1:0] dst;
      logic [P-1:0]         en;
      logic [P-1:0][W-1:0]  ed;
      logic [P-1:0]         ebp;
      logic [P-1:0]         eack;
   } vec_t;

   vec_t vecs[$];

   crossbar_rr #(.PORTS(P), .WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data_i),
      .bp_i    (bp_i),
      .dest    (dest),
      .dest_en (dest_en),
      .data_o  (data_o),
      .bp_o    (bp_o),
      .ack     (ack)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic add(input string nm, input logic [P-1:0][W-1:0] di, input logic [P-1:0] bpi,
                      input logic [P-1:0][DW-1:0] dst, input logic [P-1:0] en,
                      input logic [P-1:0][W-1:0] ed, input logic [P-1:0] ebp, input logic [P-1:0] eack);
      vec_t v;
      v.name = nm; v.di = di; v.bpi = bpi; v.dst = dst; v.en = en;
      v.ed = ed; v.ebp = ebp; v.eack = eack;
      vecs.push_back(v);
   endtask

   task automatic check_out();
      logic [EW-1:0] exp_v;
      logic [EW-1:0] got;
      string         nm;
      int            cnt;
      int            bad;
      got = {data_o, bp_o, ack};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %h, expected a queued entry", got);
         return;
      end
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s: got data_o=%h bp_o=%b ack=%b, expected data_o=%h bp_o=%b ack=%b",
                  nm, data_o, bp_o, ack, exp_v[EW-1 -: P*W], exp_v[2*P-1 -: P], exp_v[P-1:0]);
      end
      bad = 0;
      for (int o = 0; o < P; o++) begin
         cnt = 0;
         for (int i = 0; i < P; i++) begin
            if (ack[i] && dest[i] == o[DW-1:0]) cnt++;
         end
         if (cnt > 1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s_one_grant: got %0d outputs with several granted inputs, expected 0", nm, bad);
      end
   endtask

   // Drive one cycle just after the rising edge; compare on the falling edge.
   task automatic apply(input logic r, input string nm, input logic [P-1:0][W-1:0] di,
                        input logic [P-1:0] bpi, input logic [P-1:0][DW-1:0] dst,
                        input logic [P-1:0] en, input logic [P-1:0][W-1:0] ed,
                        input logic [P-1:0] ebp, input logic [P-1:0] eack);
      @(posedge clk);
      #1;
      rst     = r;
      data_i  = di;
      bp_i    = bpi;
      dest    = dst;
      dest_en = en;
      exp_q.push_back({ed, ebp, eack});
      name_q.push_back(nm);
      @(negedge clk);
      check_out();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [P-1:0][W-1:0] di;
      logic [P-1:0][W-1:0] ed;
      logic [P-1:0]        bpi;
      logic [P-1:0]        ebp;

      rst     = 1'b1;
      data_i  = 32'hD3C2B1A0;
      bp_i    = 4'b1111;
      dest    = 8'b00_11_10_01;
      dest_en = 4'b1111;

      // dest packs {d3,d2,d1,d0}; data packs {port3,port2,port1,port0}
      add("idle",          32'hD3C2B1A0, 4'b1111, 8'b00_11_10_01, 4'b0000, 32'h00000000, 4'b0000, 4'b0000);
      add("single_0to2",   32'h443322A5, 4'b0100, 8'b00_00_00_10, 4'b0001, 32'h00A50000, 4'b0001, 4'b0001);
      add("single_bp_low", 32'h443322A5, 4'b1011, 8'b00_00_00_10, 4'b0001, 32'h00A50000, 4'b0000, 4'b0001);
      add("release_a",     32'h443322A5, 4'b1111, 8'b00_00_00_10, 4'b0000, 32'h00000000, 4'b0000, 4'b0000);
      add("rr_1_wins",     32'h33221100, 4'b0001, 8'h00,          4'b1010, 32'h00000011, 4'b0010, 4'b0010);
      add("rr_1_drops",    32'h33221100, 4'b0001, 8'h00,          4'b1000, 32'h00000033, 4'b1000, 4'b1000);
      add("rr_3_locked",   32'h33221100, 4'b0001, 8'h00,          4'b1010, 32'h00000033, 4'b1000, 4'b1000);
      add("release_b",     32'h33221100, 4'b0001, 8'h00,          4'b0000, 32'h00000000, 4'b0000, 4'b0000);
      add("rr_1_again",    32'h33221100, 4'b0001, 8'h00,          4'b1010, 32'h00000011, 4'b0010, 4'b0010);
      add("release_c",     32'h33221100, 4'b0001, 8'h00,          4'b0000, 32'h00000000, 4'b0000, 4'b0000);
      add("perm_bp_0000",  32'hD3C2B1A0, 4'b0000, 8'b00_11_10_01, 4'b1111, 32'hC2B1A0D3, 4'b0000, 4'b1111);
      add("perm_bp_0101",  32'hD3C2B1A0, 4'b0101, 8'b00_11_10_01, 4'b1111, 32'hC2B1A0D3, 4'b1010, 4'b1111);
      add("perm_bp_1010",  32'hD3C2B1A0, 4'b1010, 8'b00_11_10_01, 4'b1111, 32'hC2B1A0D3, 4'b0101, 4'b1111);
      add("perm_bp_1111",  32'hD3C2B1A0, 4'b1111, 8'b00_11_10_01, 4'b1111, 32'hC2B1A0D3, 4'b1111, 4'b1111);
      add("perm_bp_0001",  32'hD3C2B1A0, 4'b0001, 8'b00_11_10_01, 4'b1111, 32'hC2B1A0D3, 4'b1000, 4'b1111);
      add("release_d",     32'hD3C2B1A0, 4'b1111, 8'b00_11_10_01, 4'b0000, 32'h00000000, 4'b0000, 4'b0000);
      add("en_mask_2",     32'hD3C2B1A0, 4'b0001, 8'h00,          4'b0100, 32'h000000C2, 4'b0100, 4'b0100);
      add("wrap_to_3",     32'hD3C2B1A0, 4'b0001, 8'h00,          4'b1011, 32'h000000D3, 4'b1000, 4'b1000);
      add("wrap_lock_3",   32'hD3C2B1A0, 4'b0001, 8'h00,          4'b1011, 32'h000000D3, 4'b1000, 4'b1000);
      add("release_e",     32'hD3C2B1A0, 4'b0001, 8'h00,          4'b0000, 32'h00000000, 4'b0000, 4'b0000);
      add("wrap_to_0",     32'hD3C2B1A0, 4'b0001, 8'h00,          4'b1011, 32'h000000A0, 4'b0001, 4'b0001);
      add("release_f",     32'hD3C2B1A0, 4'b0001, 8'h00,          4'b0000, 32'h00000000, 4'b0000, 4'b0000);

      // Reset held with every input requesting: all outputs forced low.
      apply(1'b1, "reset_hold_a", 32'hD3C2B1A0, 4'b1111, 8'b00_11_10_01, 4'b1111, 32'h0, 4'b0000, 4'b0000);
      apply(1'b1, "reset_hold_b", 32'hD3C2B1A0, 4'b1111, 8'b00_11_10_01, 4'b1111, 32'h0, 4'b0000, 4'b0000);

      for (int k = 0; k < vecs.size(); k++) begin
         apply(1'b0, vecs[k].name, vecs[k].di, vecs[k].bpi, vecs[k].dst, vecs[k].en,
               vecs[k].ed, vecs[k].ebp, vecs[k].eack);
      end

      // Lock: input 2 takes output 1, then input 0 contends for 10 cycles.
      apply(1'b0, "lock_grant_2", 32'hD3C2B1A0, 4'b0010, 8'b00_01_00_01, 4'b0100,
            32'h0000C200, 4'b0100, 4'b0100);
      for (int c = 0; c < 10; c++) begin
         for (int p = 0; p < P; p++) di[p] = 8'($urandom_range(0, 255));
         bpi    = 4'($urandom_range(0, 15));
         ed     = '0;
         ed[1]  = di[2];
         ebp    = '0;
         ebp[2] = bpi[1];
         apply(1'b0, $sformatf("lock_hold_%0d", c), di, bpi, 8'b00_01_00_01, 4'b0101, ed, ebp, 4'b0100);
      end
      apply(1'b0, "lock_handoff_0", 32'hD3C2B1A0, 4'b0010, 8'b00_01_00_01, 4'b0001,
            32'h0000A000, 4'b0001, 4'b0001);
      apply(1'b0, "release_g", 32'hD3C2B1A0, 4'b0010, 8'b00_01_00_01, 4'b0000,
            32'h0, 4'b0000, 4'b0000);

      // Reset mid-connection: inputs 1 and 2 both want output 3.
      apply(1'b0, "mid_pre_1", 32'hD3C2B1A0, 4'b1000, 8'b00_11_11_00, 4'b0110,
            32'hB1000000, 4'b0010, 4'b0010);
      apply(1'b1, "mid_rst_a", 32'hD3C2B1A0, 4'b1000, 8'b00_11_11_00, 4'b0110,
            32'h0, 4'b0000, 4'b0000);
      apply(1'b1, "mid_rst_b", 32'hD3C2B1A0, 4'b1000, 8'b00_11_11_00, 4'b0110,
            32'h0, 4'b0000, 4'b0000);
      apply(1'b0, "mid_post_1", 32'hD3C2B1A0, 4'b1000, 8'b00_11_11_00, 4'b0110,
            32'hB1000000, 4'b0010, 4'b0010);
      apply(1'b0, "mid_post_lock", 32'hD3C2B1A0, 4'b0000, 8'b00_11_11_00, 4'b0110,
            32'hB1000000, 4'b0000, 4'b0010);

      // ---------------- final report ----------------
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
